// File: rtl/pe_output_pkg.sv
// Shared types and constants for the PE result write-back stage.
// Holds the writer FSM state enum, Avalon word constants and the ReLU helper.
package pe_output_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } pe_out_state_t;

    localparam int         WORD_W = 32;
    localparam logic [3:0] BE_ALL = 4'hF;

    // Negative lanes (sign bit set) clamp to zero.
    function automatic logic [15:0] relu16(input logic [15:0] x);
        return x[15] ? 16'h0000 : x;
    endfunction

endpackage

// File: rtl/pe_output_writer.sv
// Latches the PE result vector on start, optionally applies ReLU, packs two
// lanes per 32-bit word and writes them out over an Avalon-MM write master.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 one-cycle request from the control FSM
//   base_addr             first word address, sampled with start
//   relu_en, output_en    clamp enable / write enable, sampled with start
//   pe_result             NUM_PE lanes of DATA_W bits, sampled with start
//   avm_*                 Avalon-MM write master (waitrequest honoured)
//   busy, done, overrun   status back to the control FSM
module pe_output_writer
    import pe_output_pkg::*;
#(
    parameter int NUM_PE = 16,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic                     relu_en,
    input  logic                     output_en,
    input  logic [NUM_PE*DATA_W-1:0] pe_result,
    output logic [ADDR_W-1:0]        avm_address,
    output logic                     avm_write,
    output logic [31:0]              avm_writedata,
    output logic [3:0]               avm_byteenable,
    input  logic                     avm_waitrequest,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    localparam int NWORDS = NUM_PE / 2;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int BUF_W  = NUM_PE * DATA_W;

    pe_out_state_t     state_q, state_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovr_q, ovr_d;

    logic [BUF_W-1:0]  cap;
    logic [WORD_W-1:0] word [NWORDS];
    logic              last_word;

    // Capture path: each lane passes through ReLU when enabled.
    for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
        logic [DATA_W-1:0] raw;
        assign raw = pe_result[i*DATA_W +: DATA_W];
        assign cap[i*DATA_W +: DATA_W] = relu_en ? relu16(raw) : raw;
    end

    // Word k is {lane 2k+1, lane 2k}, which is simply a 32-bit slice.
    for (genvar w = 0; w < NWORDS; w++) begin : g_word
        assign word[w] = buf_q[w*WORD_W +: WORD_W];
    end

    assign last_word = (cnt_q == CNT_W'(NWORDS - 1));

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    ovr_d = 1'b0;
                    if (output_en) begin
                        buf_d   = cap;
                        addr_d  = base_addr;
                        cnt_d   = '0;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WRITE: begin
                if (start) ovr_d = 1'b1;
                if (!avm_waitrequest) begin
                    // Address wraps naturally at 2^ADDR_W.
                    addr_d = addr_q + ADDR_W'(1);
                    if (last_word) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (start) ovr_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    // All outputs decode from registers only.
    assign avm_write      = (state_q == S_WRITE);
    assign avm_address    = addr_q;
    assign avm_writedata  = avm_write ? word[cnt_q] : '0;
    assign avm_byteenable = avm_write ? BE_ALL : 4'h0;
    assign busy           = avm_write;
    assign done           = (state_q == S_DONE);
    assign overrun        = ovr_q;

endmodule

// File: tb/tb_pe_output_writer.sv
// Randomised self-checking bench for pe_output_writer.
// Expected writes come from a queue-based model built from the lane values.
module tb_pe_output_writer;

    localparam int NUM_PE = 16;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 15;
    localparam int NW     = NUM_PE / 2;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     start = 1'b0;
    logic [ADDR_W-1:0]        base_addr = '0;
    logic                     relu_en = 1'b0;
    logic                     output_en = 1'b0;
    logic [NUM_PE*DATA_W-1:0] pe_result = '0;
    logic [ADDR_W-1:0]        avm_address;
    logic                     avm_write;
    logic [31:0]              avm_writedata;
    logic [3:0]               avm_byteenable;
    logic                     avm_waitrequest = 1'b0;
    logic                     busy;
    logic                     done;
    logic                     overrun;

    int n_chk = 0;
    int n_pass = 0;

    pe_output_writer #(
        .NUM_PE(NUM_PE),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .base_addr      (base_addr),
        .relu_en        (relu_en),
        .output_en      (output_en),
        .pe_result      (pe_result),
        .avm_address    (avm_address),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_byteenable (avm_byteenable),
        .avm_waitrequest(avm_waitrequest),
        .busy           (busy),
        .done           (done),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h",
                      tag, got, exp);
    endtask

    function automatic logic [15:0] ref_lane(input logic [15:0] v,
                                             input bit relu);
        if (relu && $signed(v) < 0) return 16'h0;
        return v;
    endfunction

    task automatic scramble();
        for (int i = 0; i < NUM_PE; i++)
            pe_result[i*DATA_W +: DATA_W] = 16'($urandom);
        base_addr = 15'($urandom);
        relu_en   = ~relu_en;
        output_en = ~output_en;
    endtask

    // wmode: 0 no stalls, 1 random stalls, 2 three stalls on word 2
    task automatic run(input string tag,
                       input logic [15:0] lanes [NUM_PE],
                       input logic [14:0] base,
                       input bit relu,
                       input bit oen,
                       input int wmode,
                       input int ovr_cyc);
        logic [14:0] qa [$];
        logic [31:0] qd [$];
        logic [14:0] pa;
        logic [31:0] pd;
        int cyc, acc, stall_n, exp_lat;
        bit seen, prev_stall, ovr_m;
        pa = '0;
        pd = '0;
        if (oen) begin
            for (int k = 0; k < NW; k++) begin
                qa.push_back(15'((int'(base) + k) % 32768));
                qd.push_back({ref_lane(lanes[2*k+1], relu),
                              ref_lane(lanes[2*k], relu)});
            end
        end
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = base;
        relu_en   = relu;
        output_en = oen;
        for (int i = 0; i < NUM_PE; i++)
            pe_result[i*DATA_W +: DATA_W] = lanes[i];
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
        cyc = 1; acc = 0; stall_n = 0;
        seen = 0; prev_stall = 0; ovr_m = 0;
        while (!seen && cyc < 100) begin
            case (wmode)
                1:       avm_waitrequest = ($urandom_range(0, 2) == 0);
                2:       avm_waitrequest = (acc == 2 && stall_n < 3);
                default: avm_waitrequest = 1'b0;
            endcase
            start = (cyc == ovr_cyc);
            @(negedge clk);
            chk({tag, " overrun"}, overrun, ovr_m);
            chk({tag, " byteenable"}, avm_byteenable,
                avm_write ? 4'hF : 4'h0);
            if (done) begin
                seen = 1;
                exp_lat = oen ? NW + 1 + stall_n : 1;
                chk({tag, " done latency"}, cyc, exp_lat);
                chk({tag, " busy at done"}, busy, 0);
                chk({tag, " write at done"}, avm_write, 0);
            end else begin
                chk({tag, " write asserted"}, avm_write, 1);
                chk({tag, " busy"}, busy, 1);
                if (prev_stall) begin
                    chk({tag, " hold addr"}, avm_address, pa);
                    chk({tag, " hold data"}, avm_writedata, pd);
                end
                if (avm_write && avm_waitrequest) begin
                    stall_n++;
                    prev_stall = 1;
                    pa = avm_address;
                    pd = avm_writedata;
                end else if (avm_write) begin
                    prev_stall = 0;
                    if (qa.size() == 0) begin
                        chk({tag, " spurious write"}, qa.size(), 1);
                    end else begin
                        chk($sformatf("%s addr w%0d", tag, acc),
                            avm_address, qa.pop_front());
                        chk($sformatf("%s data w%0d", tag, acc),
                            avm_writedata, qd.pop_front());
                    end
                    acc++;
                end
            end
            if (cyc == ovr_cyc) ovr_m = 1;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        avm_waitrequest = 1'b0;
        chk({tag, " done seen"}, seen, 1);
        chk({tag, " words left"}, qa.size(), 0);
        @(negedge clk);
        chk({tag, " done one cycle"}, done, 0);
        chk({tag, " idle busy"}, busy, 0);
        chk({tag, " idle write"}, avm_write, 0);
        chk({tag, " overrun held"}, overrun, ovr_m);
    endtask

    logic [15:0] ln [NUM_PE];

    initial begin
        #1;
        chk("rst write", avm_write, 0);
        chk("rst addr", avm_address, 0);
        chk("rst data", avm_writedata, 0);
        chk("rst be", avm_byteenable, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst overrun", overrun, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < NUM_PE; i++) ln[i] = 16'(i + 1);
        run("ramp", ln, 15'h0100, 0, 1, 0, -1);

        for (int i = 0; i < NUM_PE; i++) ln[i] = 16'($urandom);
        ln[0] = 16'hFFF0;
        ln[1] = 16'h0005;
        run("relu on", ln, 15'h0200, 1, 1, 0, -1);
        run("relu off", ln, 15'h0200, 0, 1, 0, -1);

        for (int i = 0; i < NUM_PE; i++) ln[i] = 16'($urandom);
        run("stall w2", ln, 15'h0300, 0, 1, 2, -1);

        run("wrap", ln, 15'h7FFE, 0, 1, 0, -1);
        run("no oen", ln, 15'h0400, 1, 0, 0, -1);

        run("overrun", ln, 15'h0500, 0, 1, 0, 3);
        repeat (3) @(negedge clk);
        chk("overrun sticky idle", overrun, 1);
        run("overrun clr", ln, 15'h0600, 0, 1, 0, -1);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < NUM_PE; i++) ln[i] = 16'($urandom);
            run($sformatf("rand%0d", t), ln, 15'($urandom),
                bit'($urandom_range(0, 1)),
                $urandom_range(0, 5) != 0, 1, -1);
        end

        // Reset in the middle of a burst, with overrun already set.
        @(posedge clk); #1;
        start = 1'b1; output_en = 1'b1; base_addr = 15'h0700;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        chk("pre-rst write", avm_write, 1);
        chk("pre-rst overrun", overrun, 1);
        rst_n = 1'b0;
        #1;
        chk("async rst write", avm_write, 0);
        chk("async rst busy", busy, 0);
        chk("async rst addr", avm_address, 0);
        chk("async rst be", avm_byteenable, 0);
        chk("async rst overrun", overrun, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst write", avm_write, 0);
        chk("post-rst done", done, 0);
        chk("post-rst busy", busy, 0);
        for (int i = 0; i < NUM_PE; i++) ln[i] = 16'($urandom);
        run("after rst", ln, 15'h0123, 1, 1, 1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
